floo_input_vc_sched: RTL and testbench

// - Per-input-port switch-allocation (SA) scheduler in the VC router; sequences one input port's per-VC ctrl/data FIFOs.
// - Round-robin picks one eligible VC: head valid and downstream credit OK. Raises one SA request toward that VC's output port.
// - On grant, pops the ctrl head in the SA cycle, then pops the payload and returns a credit one cycle later (ST stage).

---
 rtl/floo_input_vc_sched.sv | 196 +++++++++++++++++++
 tb/tb_floo_input_vc_sched.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/floo_input_vc_sched.sv
`default_nettype none
// ============================================================================
// Module      : floo_input_vc_sched
// Description : Per-input-port switch-allocation scheduler for a VC router.
//               Picks one eligible VC (head valid and downstream credit
//               available) round-robin and raises one SA request toward that
//               VC's output port. On grant it pops the ctrl head in the SA
//               cycle, then pops the payload and returns a credit one cycle
//               later (ST stage).
//               Optional wormhole lock: define FLOO_VC_SCHED_WORMHOLE_LOCK_EN
//               to keep the flits of one packet contiguous on this input.
// Revision    : 1.0 - initial release
// ============================================================================
module floo_input_vc_sched #(
    parameter int unsigned NumVC         = 4,
    parameter int unsigned NumVCWidth    = 2,
    parameter int unsigned NumPorts      = 5,
    parameter int unsigned NumPortsWidth = 3
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NumVC-1:0]                       vc_head_v_i,
    input  logic [NumVC-1:0]                       vc_head_last_i,
    input  logic [NumVC-1:0][NumPortsWidth-1:0]    vc_head_out_port_i,
    input  logic [NumVC-1:0]                       vc_credit_ok_i,
    output logic                                   sa_req_o,
    output logic [NumPorts-1:0]                    sa_out_port_oh_o,
    input  logic                                   sa_gnt_i,
    output logic                                   read_enable_sa_stage_o,
    output logic [NumVC-1:0]                       read_vc_id_oh_sa_stage_o,
    output logic                                   read_enable_st_stage_o,
    output logic [NumVC-1:0]                       read_vc_id_oh_st_stage_o,
    output logic [NumPorts-1:0]                    st_out_port_oh_o,
    output logic                                   locked_o
);

    logic [NumVC-1:0]         w_elig;
    logic [NumVCWidth-1:0]    r_ptr;
    logic [NumVCWidth-1:0]    w_ptr_nxt;
    logic [NumVCWidth-1:0]    w_sel;
    logic [NumVCWidth-1:0]    w_lock_vc;
    logic                     w_locked;
    logic                     w_found;
    logic                     w_port_ok;
    logic                     w_req;
    logic                     w_gnt;
    logic                     w_sel_last;
    logic                     w_adv;
    logic [NumPortsWidth-1:0] w_port;
    logic [NumVC-1:0]         w_sel_oh;
    logic [NumPorts-1:0]      w_port_oh;

    logic                     r_st_en;
    logic [NumVC-1:0]         r_st_vc_oh;
    logic [NumPorts-1:0]      r_st_port_oh;

    assign w_elig = vc_head_v_i & vc_credit_ok_i;

    // VC selection: the locked VC only, else first eligible VC at/after the pointer with wrap
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        if (w_locked) begin
            w_sel   = w_lock_vc;
            w_found = w_elig[w_lock_vc];
        end else begin
            for (int unsigned v = 0; v < NumVC; v++) begin
                if (!w_found && w_elig[v] && (v >= 32'(r_ptr))) begin
                    w_found = 1'b1;
                    w_sel   = NumVCWidth'(v);
                end
            end
            for (int unsigned v = 0; v < NumVC; v++) begin
                if (!w_found && w_elig[v] && (v < 32'(r_ptr))) begin
                    w_found = 1'b1;
                    w_sel   = NumVCWidth'(v);
                end
            end
        end
    end

    // Request qualification; an out-of-range port index suppresses the request, reset masks all
    assign w_port     = vc_head_out_port_i[w_sel];
    assign w_port_ok  = (32'(w_port) < NumPorts);
    assign w_req      = rst_ni & w_found & w_port_ok;
    assign w_gnt      = w_req & sa_gnt_i;
    assign w_sel_last = vc_head_last_i[w_sel];
    assign w_ptr_nxt  = (32'(w_sel) == (NumVC - 1)) ? '0 : (w_sel + 1'b1);

    // One-hot decode of the selected VC and its target port, zero when not requesting
    always_comb begin
        w_sel_oh  = '0;
        w_port_oh = '0;
        for (int unsigned v = 0; v < NumVC; v++) begin
            w_sel_oh[v] = w_req & (32'(w_sel) == v);
        end
        for (int unsigned p = 0; p < NumPorts; p++) begin
            w_port_oh[p] = w_req & (32'(w_port) == p);
        end
    end

`ifdef FLOO_VC_SCHED_WORMHOLE_LOCK_EN
    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } lock_state_e;

    lock_state_e           r_state;
    logic [NumVCWidth-1:0] r_lock_vc;
    logic                  r_locked;

    // Wormhole lock: a granted non-tail flit pins the VC until its tail is granted
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_lock_vc <= '0;
            r_locked  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt && !w_sel_last) begin
                        r_state   <= S_LOCKED;
                        r_lock_vc <= w_sel;
                        r_locked  <= 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (w_gnt && w_sel_last) begin
                        r_state  <= S_IDLE;
                        r_locked <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign w_locked  = r_locked;
    assign w_lock_vc = r_lock_vc;
    assign w_adv     = w_gnt & w_sel_last;
    assign locked_o  = r_locked;
`else
    assign w_locked  = 1'b0;
    assign w_lock_vc = '0;
    assign w_adv     = w_gnt;
    assign locked_o  = 1'b0;
`endif

    // Round-robin pointer moves past the granted VC once its packet (or flit) is done
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
        end else if (w_adv) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // ST stage: capture this cycle's grant every cycle, zeros when nothing was granted
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_st_en      <= 1'b0;
            r_st_vc_oh   <= '0;
            r_st_port_oh <= '0;
        end else begin
            r_st_en      <= w_gnt;
            r_st_vc_oh   <= w_sel_oh & {NumVC{w_gnt}};
            r_st_port_oh <= w_port_oh & {NumPorts{w_gnt}};
        end
    end

    assign sa_req_o                 = w_req;
    assign sa_out_port_oh_o         = w_port_oh;
    assign read_enable_sa_stage_o   = w_gnt;
    assign read_vc_id_oh_sa_stage_o = w_sel_oh & {NumVC{w_gnt}};
    assign read_enable_st_stage_o   = r_st_en;
    assign read_vc_id_oh_st_stage_o = r_st_vc_oh;
    assign st_out_port_oh_o         = r_st_port_oh;

`ifndef SYNTHESIS
    a_port_oh0: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(sa_out_port_oh_o));
    a_sa_vc_oh0: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(read_vc_id_oh_sa_stage_o));
    a_st_vc_oh0: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(read_vc_id_oh_st_stage_o));
    a_st_after_sa: assert property (@(posedge clk_i) disable iff (!rst_ni)
        read_enable_st_stage_o |-> $past(read_enable_sa_stage_o));
    a_port_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_found |-> w_port_ok);
`endif

endmodule
`default_nettype wire

// File: tb/tb_floo_input_vc_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_floo_input_vc_sched
// Description : Directed self-checking bench for floo_input_vc_sched
//               (NumVC=4, NumPorts=5). Head ports: VC0->1, VC1->3, VC2->2,
//               VC3->4. Wormhole scenarios follow
//               FLOO_VC_SCHED_WORMHOLE_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_floo_input_vc_sched;

    logic            clk_i;
    logic            rst_ni;
    logic [3:0]      vc_head_v_i;
    logic [3:0]      vc_head_last_i;
    logic [3:0][2:0] vc_head_out_port_i;
    logic [3:0]      vc_credit_ok_i;
    logic            sa_req_o;
    logic [4:0]      sa_out_port_oh_o;
    logic            sa_gnt_i;
    logic            read_enable_sa_stage_o;
    logic [3:0]      read_vc_id_oh_sa_stage_o;
    logic            read_enable_st_stage_o;
    logic [3:0]      read_vc_id_oh_st_stage_o;
    logic [4:0]      st_out_port_oh_o;
    logic            locked_o;

    int n_tests;
    int n_fail;

    floo_input_vc_sched #(
        .NumVC        (4),
        .NumVCWidth   (2),
        .NumPorts     (5),
        .NumPortsWidth(3)
    ) dut (
        .clk_i                   (clk_i),
        .rst_ni                  (rst_ni),
        .vc_head_v_i             (vc_head_v_i),
        .vc_head_last_i          (vc_head_last_i),
        .vc_head_out_port_i      (vc_head_out_port_i),
        .vc_credit_ok_i          (vc_credit_ok_i),
        .sa_req_o                (sa_req_o),
        .sa_out_port_oh_o        (sa_out_port_oh_o),
        .sa_gnt_i                (sa_gnt_i),
        .read_enable_sa_stage_o  (read_enable_sa_stage_o),
        .read_vc_id_oh_sa_stage_o(read_vc_id_oh_sa_stage_o),
        .read_enable_st_stage_o  (read_enable_st_stage_o),
        .read_vc_id_oh_st_stage_o(read_vc_id_oh_st_stage_o),
        .st_out_port_oh_o        (st_out_port_oh_o),
        .locked_o                (locked_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Port one-hot that a given VC's head routes to (bench-side table)
    function automatic logic [4:0] port_oh_of(input int vc);
        case (vc)
            0:       return 5'b00010;
            1:       return 5'b01000;
            2:       return 5'b00100;
            3:       return 5'b10000;
            default: return 5'b00000;
        endcase
    endfunction

    task automatic set_in(input logic [3:0] v, input logic [3:0] last,
                          input logic [3:0] cr, input logic gnt);
        vc_head_v_i    = v;
        vc_head_last_i = last;
        vc_credit_ok_i = cr;
        sa_gnt_i       = gnt;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        set_in(4'b0000, 4'b1111, 4'b1111, 1'b0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        set_in(4'b1111, 4'b1111, 4'b1111, 1'b1);
        #1;
        n_tests++;
        if (sa_req_o !== 1'b0 || sa_out_port_oh_o !== 5'b0 || read_enable_sa_stage_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_sa: req=%b port=%b pop=%b, want 0/00000/0",
                     sa_req_o, sa_out_port_oh_o, read_enable_sa_stage_o);
        end
        @(posedge clk_i); #1;
        n_tests++;
        if (read_enable_st_stage_o !== 1'b0 || read_vc_id_oh_st_stage_o !== 4'b0 ||
            st_out_port_oh_o !== 5'b0 || locked_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_st: st=%b vc=%b port=%b locked=%b, want all 0",
                     read_enable_st_stage_o, read_vc_id_oh_st_stage_o, st_out_port_oh_o, locked_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        n_tests++;
        if (sa_req_o !== 1'b1 || read_vc_id_oh_sa_stage_o !== 4'b0001 || sa_out_port_oh_o !== 5'b00010) begin
            n_fail++;
            $display("FAIL reset_release: req=%b vc=%b port=%b, want 1/0001/00010",
                     sa_req_o, read_vc_id_oh_sa_stage_o, sa_out_port_oh_o);
        end
        do_reset();
    endtask

    task automatic test_rr_fairness();
        logic [3:0] exp_oh;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            exp_oh = 4'b0001 << (c % 4);
            @(negedge clk_i);
            set_in(4'b1111, 4'b1111, 4'b1111, 1'b1);
            #1;
            n_tests++;
            if (read_enable_sa_stage_o !== 1'b1 || read_vc_id_oh_sa_stage_o !== exp_oh ||
                sa_out_port_oh_o !== port_oh_of(c % 4)) begin
                n_fail++;
                $display("FAIL rr_sa[%0d]: pop=%b vc=%b port=%b, want 1/%b/%b", c,
                         read_enable_sa_stage_o, read_vc_id_oh_sa_stage_o, sa_out_port_oh_o,
                         exp_oh, port_oh_of(c % 4));
            end
            @(posedge clk_i); #1;
            n_tests++;
            if (read_enable_st_stage_o !== 1'b1 || read_vc_id_oh_st_stage_o !== exp_oh ||
                st_out_port_oh_o !== port_oh_of(c % 4)) begin
                n_fail++;
                $display("FAIL rr_st[%0d]: st=%b vc=%b port=%b, want 1/%b/%b", c,
                         read_enable_st_stage_o, read_vc_id_oh_st_stage_o, st_out_port_oh_o,
                         exp_oh, port_oh_of(c % 4));
            end
        end
    endtask

    task automatic test_credit_gating();
        int seq_a [6] = '{0, 1, 3, 0, 1, 3};
        int seq_b [4] = '{0, 1, 2, 3};
        logic [3:0] exp_oh;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            exp_oh = 4'b0001 << seq_a[c];
            @(negedge clk_i);
            set_in(4'b1111, 4'b1111, 4'b1011, 1'b1);
            #1;
            n_tests++;
            if (read_vc_id_oh_sa_stage_o !== exp_oh) begin
                n_fail++;
                $display("FAIL credit_gap[%0d]: vc=%b, want %b", c, read_vc_id_oh_sa_stage_o, exp_oh);
            end
        end
        for (int c = 0; c < 4; c++) begin
            exp_oh = 4'b0001 << seq_b[c];
            @(negedge clk_i);
            set_in(4'b1111, 4'b1111, 4'b1111, 1'b1);
            #1;
            n_tests++;
            if (read_vc_id_oh_sa_stage_o !== exp_oh) begin
                n_fail++;
                $display("FAIL credit_back[%0d]: vc=%b, want %b", c, read_vc_id_oh_sa_stage_o, exp_oh);
            end
        end
    endtask

    task automatic test_no_grant();
        do_reset();
        // Grant VC0 once so the pointer sits at VC1
        @(negedge clk_i);
        set_in(4'b0001, 4'b1111, 4'b1111, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            set_in(4'b0011, 4'b1111, 4'b1111, 1'b0);
            #1;
            n_tests++;
            if (sa_req_o !== 1'b1 || sa_out_port_oh_o !== 5'b01000 || read_enable_sa_stage_o !== 1'b0 ||
                read_vc_id_oh_sa_stage_o !== 4'b0000) begin
                n_fail++;
                $display("FAIL nogrant_sa[%0d]: req=%b port=%b pop=%b vc=%b, want 1/01000/0/0000", c,
                         sa_req_o, sa_out_port_oh_o, read_enable_sa_stage_o, read_vc_id_oh_sa_stage_o);
            end
            @(posedge clk_i); #1;
            n_tests++;
            if (read_enable_st_stage_o !== 1'b0 || read_vc_id_oh_st_stage_o !== 4'b0000) begin
                n_fail++;
                $display("FAIL nogrant_st[%0d]: st=%b vc=%b, want 0/0000", c,
                         read_enable_st_stage_o, read_vc_id_oh_st_stage_o);
            end
        end
        @(negedge clk_i);
        set_in(4'b0011, 4'b1111, 4'b1111, 1'b1);
        #1;
        n_tests++;
        if (read_enable_sa_stage_o !== 1'b1 || read_vc_id_oh_sa_stage_o !== 4'b0010) begin
            n_fail++;
            $display("FAIL nogrant_pop: pop=%b vc=%b, want 1/0010", read_enable_sa_stage_o,
                     read_vc_id_oh_sa_stage_o);
        end
        @(posedge clk_i); #1;
        n_tests++;
        if (read_enable_st_stage_o !== 1'b1 || read_vc_id_oh_st_stage_o !== 4'b0010 ||
            st_out_port_oh_o !== 5'b01000) begin
            n_fail++;
            $display("FAIL nogrant_st_pop: st=%b vc=%b port=%b, want 1/0010/01000",
                     read_enable_st_stage_o, read_vc_id_oh_st_stage_o, st_out_port_oh_o);
        end
    endtask

`ifdef FLOO_VC_SCHED_WORMHOLE_LOCK_EN
    task automatic test_wormhole();
        logic [3:0] cr [4]   = '{4'b1111, 4'b1011, 4'b1111, 4'b1111};
        logic [3:0] last [4] = '{4'b1011, 4'b1011, 4'b1011, 4'b1111};
        logic [3:0] exp_vc [4] = '{4'b0100, 4'b0000, 4'b0100, 4'b0100};
        logic       exp_lk [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        @(negedge clk_i);
        set_in(4'b0010, 4'b1111, 4'b1111, 1'b1);   // pointer -> 2
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            set_in(4'b0101, last[c], cr[c], 1'b1);
            #1;
            n_tests++;
            if (read_vc_id_oh_sa_stage_o !== exp_vc[c] || sa_req_o !== (exp_vc[c] != 4'b0000)) begin
                n_fail++;
                $display("FAIL worm_sa[%0d]: req=%b vc=%b, want vc %b", c, sa_req_o,
                         read_vc_id_oh_sa_stage_o, exp_vc[c]);
            end
            @(posedge clk_i); #1;
            n_tests++;
            if (locked_o !== exp_lk[c]) begin
                n_fail++;
                $display("FAIL worm_lock[%0d]: locked=%b, want %b", c, locked_o, exp_lk[c]);
            end
        end
        @(negedge clk_i);
        set_in(4'b0001, 4'b1111, 4'b1111, 1'b1);
        #1;
        n_tests++;
        if (read_vc_id_oh_sa_stage_o !== 4'b0001 || sa_out_port_oh_o !== 5'b00010) begin
            n_fail++;
            $display("FAIL worm_after: vc=%b port=%b, want 0001/00010", read_vc_id_oh_sa_stage_o,
                     sa_out_port_oh_o);
        end
    endtask
`else
    task automatic test_no_lock();
        logic [3:0] exp_vc [3] = '{4'b0100, 4'b0001, 4'b0100};
        do_reset();
        @(negedge clk_i);
        set_in(4'b0010, 4'b1111, 4'b1111, 1'b1);   // pointer -> 2
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            set_in(4'b0101, 4'b0000, 4'b1111, 1'b1);
            #1;
            n_tests++;
            if (read_vc_id_oh_sa_stage_o !== exp_vc[c]) begin
                n_fail++;
                $display("FAIL nolock_sa[%0d]: vc=%b, want %b", c, read_vc_id_oh_sa_stage_o, exp_vc[c]);
            end
            @(posedge clk_i); #1;
            n_tests++;
            if (locked_o !== 1'b0) begin
                n_fail++;
                $display("FAIL nolock_locked[%0d]: locked=%b, want 0", c, locked_o);
            end
        end
    endtask
`endif

    task automatic test_reset_mid_packet();
        do_reset();
        @(negedge clk_i);
        set_in(4'b0001, 4'b0000, 4'b1111, 1'b1);
        @(posedge clk_i); #1;
        n_tests++;
        if (read_enable_st_stage_o !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pending: st=%b, want 1", read_enable_st_stage_o);
        end
        #1;
        rst_ni = 1'b0;
        #1;
        n_tests++;
        if (read_enable_st_stage_o !== 1'b0 || read_vc_id_oh_st_stage_o !== 4'b0 ||
            locked_o !== 1'b0 || sa_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst: st=%b vc=%b locked=%b req=%b, want 0/0000/0/0",
                     read_enable_st_stage_o, read_vc_id_oh_st_stage_o, locked_o, sa_req_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        set_in(4'b0000, 4'b1111, 4'b1111, 1'b0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_ni  = 1'b0;
        vc_head_out_port_i[0] = 3'd1;
        vc_head_out_port_i[1] = 3'd3;
        vc_head_out_port_i[2] = 3'd2;
        vc_head_out_port_i[3] = 3'd4;
        set_in(4'b0000, 4'b1111, 4'b1111, 1'b0);
        repeat (2) @(posedge clk_i);
        test_reset();
        test_rr_fairness();
        test_credit_gating();
        test_no_grant();
`ifdef FLOO_VC_SCHED_WORMHOLE_LOCK_EN
        test_wormhole();
`else
        test_no_lock();
`endif
        test_reset_mid_packet();
        repeat (2) @(posedge clk_i);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
